divider_toplevel: RTL
=====================

# divider_toplevel

Sequential 8-bit unsigned restoring divider for the lab board. It is the inverse companion to the lab shift-add multiplier and is driven from the same slider-switch and push-button front end. The divisor is loaded from the switches, and a Run press divides the switch value by the stored divisor over 8 iteration cycles. Quotient and remainder are shown on four hex displays.

## Interface
No parameters. The width is fixed at 8 bits.
- Clk  input  1  system clock, 50 MHz
- Reset  input  1  asynchronous, active-low reset (push-button 0)
- ClearR_LoadD  input  1  active-high, already synchronized: load divisor from S and clear remainder
- Run  input  1  active-high, already synchronized: start a division with dividend S
- S  input  8  slider switches; supply divisor or dividend
- Qval  output  8  quotient register
- Rval  output  8  remainder register
- Dval  output  8  divisor register
- QhexU, QhexL  output  7 each  seven-segment codes for Qval[7:4] and Qval[3:0]
- RhexU, RhexL  output  7 each  seven-segment codes for Rval[7:4] and Rval[3:0]
- Done  output  1  high while the FSM is in DONE
- DivZero  output  1  divisor was 0 when the current or last division started

## Operation
- Registers:
  - Q[7:0] holds the dividend, then the quotient.
  - R[7:0] holds the remainder.
  - D[7:0] holds the divisor.
  - cnt[2:0] counts iterations.
  - A 2-bit state register holds the FSM state.
- Hex outputs are combinational decodes of Q and R.
  - Segments are active-low, ordered gfedcba.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If ClearR_LoadD=1: D<=S and R<=0. Q is unchanged and the FSM stays in IDLE. ClearR_LoadD has priority over Run in the same cycle.
  - Else if Run=1: Q<=S, R<=0, cnt<=0, DivZero<=(D==0), then go to CALC.
- CALC, one iteration per cycle:
  - Form the 9-bit value T = {R, Q[7]} and the 9-bit difference T - {1'b0, D}.
  - If the difference is non-negative: R<=difference[7:0] and Q<={Q[6:0],1}.
  - Otherwise: R<=T[7:0] and Q<={Q[6:0],0}.
  - cnt increments each cycle. When cnt==7, go to DONE.
  - Run and ClearR_LoadD are ignored throughout CALC.
- DONE:
  - Q and R are held.
  - ClearR_LoadD=1 loads D<=S and clears R<=0, then stays in DONE.
  - Run=0 goes to IDLE. Run held high keeps the FSM in DONE, so there is no auto-restart.
- Divide by zero needs no special datapath. The algorithm naturally yields Q=0xFF and R=dividend, and DivZero=1 flags it.
- Invariant: at every CALC cycle R < D when D != 0, so a 9-bit trial subtraction never overflows.

## Timing
- Reset (Reset=0, asynchronous) drives the following immediately, independent of Clk:
  - Q=0, R=0, D=0, cnt=0, state=IDLE, Done=0, DivZero=0.
  - All hex outputs show 1000000.
- Reset asserted mid-CALC aborts the division. Registers return to their reset values with no partial result retained.
- Run is sampled high in IDLE at edge k. The dividend is captured at edge k, and iterations occur at edges k+1 through k+8.
- Final Qval/Rval and Done=1 are valid after edge k+8. Total latency is 8 cycles from the Run-sampling edge.
- Done falls on the edge where Run=0 is sampled in DONE. Qval and Rval stay valid in IDLE until the next start or load.
- A new division needs Run low for at least 1 cycle, then high again.

## Test plan
- Reset; S=7, ClearR_LoadD 1 cycle; S=100, Run -> after 8 cycles Qval=14, Rval=2, Done=1, DivZero=0, QhexU=1000000, QhexL=0000110.
- D=1, dividend 255 -> Qval=0xFF, Rval=0; D=200, dividend 3 -> Qval=0, Rval=3.
- D=0, dividend 5 -> Qval=0xFF, Rval=5, DivZero=1. A following run with D=5 and dividend 5 gives Qval=1, Rval=0, DivZero=0.
- Run held high for 30 cycles -> exactly one division and Done stays high. Release Run for 1 cycle, then reassert -> a new division starts.
- ClearR_LoadD and Run both high in IDLE -> D loads and the FSM stays IDLE that cycle. ClearR_LoadD pulsed during CALC -> ignored, D unchanged.
- Assert Reset asynchronously (mid-cycle) at iteration 4 -> all outputs at reset values before the next edge, and the FSM is in IDLE.

Source files
------------

// File: rtl/divider_toplevel.sv
// Sequential 8-bit unsigned restoring divider: divisor loaded from S, dividend
// captured on Run, one quotient bit per cycle, results shown on hex displays.
module divider_toplevel (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ClearR_LoadD,
  input  logic       Run,
  input  logic [7:0] S,
  output logic [7:0] Qval,
  output logic [7:0] Rval,
  output logic [7:0] Dval,
  output logic [6:0] QhexU,
  output logic [6:0] QhexL,
  output logic [6:0] RhexU,
  output logic [6:0] RhexL,
  output logic       Done,
  output logic       DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] q_q, r_q, d_q;
  logic [2:0] cnt_q;
  logic       done_q, div_zero_q;

  logic [8:0] trial, diff;
  logic [7:0] q_d, r_d;

  // One restoring step: shift the next dividend bit into R and try to subtract D.
  // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    trial = {r_q, q_q[7]};
    diff  = trial - {1'b0, d_q};
    q_d   = {q_q[6:0], 1'b0};
    r_d   = trial[7:0];
    if (trial >= {1'b0, d_q}) begin
      q_d = {q_q[6:0], 1'b1};
      r_d = diff[7:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      q_q        <= 8'd0;
      r_q        <= 8'd0;
      d_q        <= 8'd0;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ClearR_LoadD) begin
            d_q <= S;
            r_q <= 8'd0;
          end else if (Run) begin
            q_q        <= S;
            r_q        <= 8'd0;
            cnt_q      <= 3'd0;
            div_zero_q <= (d_q == 8'd0);
            state_q    <= CALC;
          end
        end
        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // Holding Run high parks here; a fresh start needs Run to drop first.
          if (ClearR_LoadD) begin
            d_q <= S;
            r_q <= 8'd0;
          end else if (!Run) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Active-low segments, ordered gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign Qval    = q_q;
  assign Rval    = r_q;
  assign Dval    = d_q;
  assign Done    = done_q;
  assign DivZero = div_zero_q;
  assign QhexU   = hex7(q_q[7:4]);
  assign QhexL   = hex7(q_q[3:0]);
  assign RhexU   = hex7(r_q[7:4]);
  assign RhexL   = hex7(r_q[3:0]);

endmodule
